modred_quot_correct: RTL and testbench

//   Downstream consumer of the 2-bit upper-product quotient estimate in the modular-reduction path.

---
 rtl/modred_pkg.sv | 26 ++
 rtl/modred_cond_sub.sv | 24 ++
 rtl/modred_quot_correct.sv | 208 ++++++++++++++++++++
 tb/tb_modred_quot_correct.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/modred_pkg.sv
// Shared definitions for the modular-reduction quotient-correction stage:
// FSM state encoding and default datapath widths / correction bound.
package modred_pkg;

  localparam int W_DEF        = 56;
  localparam int XW_DEF       = 58;
  localparam int MAX_CORR_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MULSUB = 2'd1,
    ST_CORR   = 2'd2,
    ST_DONE   = 2'd3
  } modred_state_e;

  // Width of a counter that must hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/modred_cond_sub.sv
// Conditional subtractor: y = (a >= b) ? a - b : a, with the comparison
// result exported as ge. Purely combinational.
module modred_cond_sub
  import modred_pkg::*;
#(
  parameter int XW = XW_DEF
) (
  input  logic [XW-1:0] a,
  input  logic [XW-1:0] b,
  output logic [XW-1:0] y,
  output logic          ge
);

  // Compare and select the reduced or unreduced operand
  always_comb begin
    ge = (a >= b);
    if (ge) begin
      y = a - b;
    end else begin
      y = a;
    end
  end

endmodule

// File: rtl/modred_quot_correct.sv
// Quotient-estimate correction stage of the modular-reduction path.
// Computes r = x - q*m and then subtracts m while r >= m, at most MAX_CORR
// times; err flags a borrow on x - q*m or a residue still >= m afterwards.
// One job in flight; valid/ready handshakes on input and output.
// Build option: define MODRED_PARALLEL_CORR_EN to resolve all corrections in
// a single chained evaluation (fixed latency 3) instead of one per cycle.
module modred_quot_correct
  import modred_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int XW       = XW_DEF,
  parameter int MAX_CORR = MAX_CORR_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] x,
  input  logic [1:0]    q,
  input  logic [W-1:0]  m,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  r,
  output logic          err
);

  localparam int             CW       = cnt_width(MAX_CORR);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_CORR);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

  modred_state_e state_r, state_nxt_s;

  logic [XW-1:0] x_r, x_nxt_s;
  logic [1:0]    q_r, q_nxt_s;
  logic [W-1:0]  m_r, m_nxt_s;
  logic [XW-1:0] work_r, work_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [W-1:0]  r_r, r_nxt_s;
  logic          err_r, err_nxt_s;
  logic          in_ready_r;
  logic          out_valid_r;

  logic [XW-1:0] m_ext_s;
  logic [XW-1:0] qm_s;
  logic [XW:0]   d_s;

  assign m_ext_s = {{(XW-W){1'b0}}, m_r};

  // q*m as shift/add; q is at most 3 so the product fits in XW bits
  always_comb begin
    case (q_r)
      2'd0:    qm_s = {XW{1'b0}};
      2'd1:    qm_s = m_ext_s;
      2'd2:    qm_s = m_ext_s << 1;
      2'd3:    qm_s = (m_ext_s << 1) + m_ext_s;
      default: qm_s = {XW{1'b0}};
    endcase
  end

  // One extra bit so the MSB of the difference is the borrow
  assign d_s = {1'b0, x_r} - {1'b0, qm_s};

`ifdef MODRED_PARALLEL_CORR_EN
  // Chain of conditional subtractors: stage j yields r - j*m clipped at the
  // first value below m, which is exactly what the iterative loop produces.
  logic [XW-1:0]       chain_s [0:MAX_CORR];
  logic [MAX_CORR-1:0] chain_ge_s;
  logic                par_ge_s;

  assign chain_s[0] = work_r;

  for (genvar j = 0; j < MAX_CORR; j++) begin : g_chain
    modred_cond_sub #(.XW(XW)) u_sub (
      .a  (chain_s[j]),
      .b  (m_ext_s),
      .y  (chain_s[j+1]),
      .ge (chain_ge_s[j])
    );
  end

  assign par_ge_s = (chain_s[MAX_CORR] >= m_ext_s);
`else
  logic [XW-1:0] sub_y_s;
  logic          sub_ge_s;

  modred_cond_sub #(.XW(XW)) u_sub (
    .a  (work_r),
    .b  (m_ext_s),
    .y  (sub_y_s),
    .ge (sub_ge_s)
  );
`endif

  // Next-state and next-datapath logic for the job FSM
  always_comb begin
    state_nxt_s = state_r;
    x_nxt_s     = x_r;
    q_nxt_s     = q_r;
    m_nxt_s     = m_r;
    work_nxt_s  = work_r;
    cnt_nxt_s   = cnt_r;
    r_nxt_s     = r_r;
    err_nxt_s   = err_r;

    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          x_nxt_s     = x;
          q_nxt_s     = q;
          m_nxt_s     = m;
          cnt_nxt_s   = CNT_ZERO;
          err_nxt_s   = 1'b0;
          state_nxt_s = ST_MULSUB;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_MULSUB: begin
        if (d_s[XW]) begin
          // Estimate overshot: report the wrapped difference and skip correction
          err_nxt_s   = 1'b1;
          r_nxt_s     = d_s[W-1:0];
          state_nxt_s = ST_DONE;
        end else begin
          work_nxt_s  = d_s[XW-1:0];
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_CORR;
        end
      end

      ST_CORR: begin
`ifdef MODRED_PARALLEL_CORR_EN
        // First cycle captures the chained result, second cycle publishes it
        if (cnt_r == CNT_ZERO) begin
          work_nxt_s  = chain_s[MAX_CORR];
          err_nxt_s   = par_ge_s;
          cnt_nxt_s   = CNT_ONE;
          state_nxt_s = ST_CORR;
        end else begin
          r_nxt_s     = work_r[W-1:0];
          state_nxt_s = ST_DONE;
        end
`else
        if (!sub_ge_s) begin
          r_nxt_s     = work_r[W-1:0];
          err_nxt_s   = 1'b0;
          state_nxt_s = ST_DONE;
        end else if (cnt_r == CNT_MAX) begin
          r_nxt_s     = work_r[W-1:0];
          err_nxt_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          work_nxt_s  = sub_y_s;
          cnt_nxt_s   = cnt_r + CNT_ONE;
          state_nxt_s = ST_CORR;
        end
`endif
      end

      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      x_r         <= {XW{1'b0}};
      q_r         <= 2'd0;
      m_r         <= {W{1'b0}};
      work_r      <= {XW{1'b0}};
      cnt_r       <= CNT_ZERO;
      r_r         <= {W{1'b0}};
      err_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      x_r         <= x_nxt_s;
      q_r         <= q_nxt_s;
      m_r         <= m_nxt_s;
      work_r      <= work_nxt_s;
      cnt_r       <= cnt_nxt_s;
      r_r         <= r_nxt_s;
      err_r       <= err_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign r         = r_r;
  assign err       = err_r;

endmodule

// File: tb/tb_modred_quot_correct.sv
// Directed, table-driven bench for modred_quot_correct plus hand-written
// sequences for backpressure and mid-job reset.
module tb_modred_quot_correct;

  localparam int W  = 56;
  localparam int XW = 58;
  localparam int NV = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] x;
  logic [1:0]    q;
  logic [W-1:0]  m;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  r;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [XW-1:0] x;
    logic [1:0]    q;
    logic [W-1:0]  m;
    logic [W-1:0]  r;
    logic          err;
    int            lat;
    bit            borrow;
  } vec_t;

  vec_t vecs [NV];

  modred_quot_correct dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .q         (q),
    .m         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one job, wait for out_valid; latency counts edges after the accept edge.
  task automatic do_job(input logic [XW-1:0] xi, input logic [1:0] qi, input logic [W-1:0] mi,
                        output int lat, output bit to);
    @(negedge clk);
    in_valid = 1'b1;
    x = xi;
    q = qi;
    m = mi;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    to = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) to = 1'b1;
  endtask

  initial begin
    int  lat;
    bit  to;
    int  exp_lat;
    logic [W-1:0] ones;

    ones = {W{1'b1}};
    //          x                        q     m               r                       err   lat borrow
    vecs[0]  = '{58'd20,                 2'd2, 56'd7,          56'd6,                  1'b0, 2, 1'b0};
    vecs[1]  = '{58'd27,                 2'd2, 56'd7,          56'd6,                  1'b0, 3, 1'b0};
    vecs[2]  = '{58'd10,                 2'd2, 56'd7,          ones - 56'd3,           1'b1, 2, 1'b1};
    vecs[3]  = '{58'd100,                2'd0, 56'd7,          56'd79,                 1'b1, 5, 1'b0};
    vecs[4]  = '{58'd5,                  2'd1, 56'd0,          56'd5,                  1'b1, 5, 1'b0};
    vecs[5]  = '{58'd3999,               2'd3, 56'd1000,       56'd999,                1'b0, 2, 1'b0};
    vecs[6]  = '{58'h200_0000_0000_0003, 2'd1, ones,           56'd5,                  1'b0, 3, 1'b0};
    vecs[7]  = '{58'd14,                 2'd1, 56'd7,          56'd0,                  1'b0, 3, 1'b0};
    vecs[8]  = '{58'd24,                 2'd1, 56'd7,          56'd3,                  1'b0, 4, 1'b0};
    vecs[9]  = '{58'd27,                 2'd0, 56'd7,          56'd6,                  1'b0, 5, 1'b0};
    vecs[10] = '{58'd28,                 2'd0, 56'd7,          56'd7,                  1'b1, 5, 1'b0};
    vecs[11] = '{58'd0,                  2'd3, 56'd1,          ones - 56'd2,           1'b1, 2, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    q = 2'd0;
    m = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_r", {8'd0, r}, 64'd0);
    check("reset_err", {63'd0, err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven jobs with immediate downstream acceptance
    for (int i = 0; i < NV; i++) begin
`ifdef MODRED_PARALLEL_CORR_EN
      exp_lat = vecs[i].borrow ? 2 : 3;
`else
      exp_lat = vecs[i].lat;
`endif
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
      do_job(vecs[i].x, vecs[i].q, vecs[i].m, lat, to);
      check($sformatf("v%0d_timeout", i), {63'd0, to}, 64'd0);
      check($sformatf("v%0d_r", i), {8'd0, r}, {8'd0, vecs[i].r});
      check($sformatf("v%0d_err", i), {63'd0, err}, {63'd0, vecs[i].err});
      if (vecs[i].borrow) begin
        // Borrow skips correction; it must be no slower than the shortest normal path
        check($sformatf("v%0d_lat_le", i), {63'd0, (lat >= 1 && lat <= exp_lat)}, 64'd1);
      end else begin
        check($sformatf("v%0d_lat", i), lat, exp_lat);
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid_drop", i), {63'd0, out_valid}, 64'd0);
    end

    // Backpressure: hold result in DONE, ignore stray in_valid pulses
    out_ready = 1'b0;
    do_job(58'd20, 2'd2, 56'd7, lat, to);
    check("bp_timeout", {63'd0, to}, 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (c % 2 == 0);
      x = 58'd1;
      q = 2'd0;
      m = 56'd1;
      check($sformatf("bp%0d_in_ready", c), {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_out_valid", c), {63'd0, out_valid}, 64'd1);
      check($sformatf("bp%0d_r", c), {8'd0, r}, 64'd6);
      check($sformatf("bp%0d_err", c), {63'd0, err}, 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_in_ready_done", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    do_job(58'd27, 2'd2, 56'd7, lat, to);
    check("bp_next_timeout", {63'd0, to}, 64'd0);
    check("bp_next_r", {8'd0, r}, 64'd6);
    check("bp_next_err", {63'd0, err}, 64'd0);
    @(posedge clk);
    #1;

    // Reset during CORR aborts the job without emitting a result
    @(negedge clk);
    in_valid = 1'b1;
    x = 58'd100;
    q = 2'd0;
    m = 56'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_r", {8'd0, r}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_quiet%0d", c), {63'd0, out_valid}, 64'd0);
    end
    do_job(58'd20, 2'd2, 56'd7, lat, to);
    check("rst_next_timeout", {63'd0, to}, 64'd0);
    check("rst_next_r", {8'd0, r}, 64'd6);
    check("rst_next_err", {63'd0, err}, 64'd0);
`ifdef MODRED_PARALLEL_CORR_EN
    check("rst_next_lat", lat, 3);
`else
    check("rst_next_lat", lat, 2);
`endif
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
